ahb_slave_controller: RTL

AHB-Lite bus-side front end of the USB endpoint slave. Samples address phases and decodes them into register-location codes. Sequences the data phase, including multi-cycle data-buffer accesses and timeouts. Generates hready/hresp per AHB-Lite. Drives val_loc, hwrite_reg and state into value_registers and consumes its hold.

---
 rtl/ahb_slave_controller_if.sv | 20 ++
 rtl/ahb_slave_controller.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ahb_slave_controller_if.sv
// AHB-Lite bus signals between the bus master and the endpoint slave front end.
interface ahb_slave_controller_if;
  logic       hsel;
  logic [3:0] haddr;
  logic [1:0] htrans;
  logic [1:0] hsize;
  logic       hwrite;
  logic       hready;
  logic       hresp;

  modport master (
    output hsel, haddr, htrans, hsize, hwrite,
    input  hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite,
    output hready, hresp
  );
endinterface

// File: rtl/ahb_slave_controller.sv
// AHB-Lite slave front end: samples address phases, decodes register
// locations, sequences data phases (including buffer waits with timeout)
// and produces hready/hresp.
// Optional macro AHB_RO_WRITE_ERR_EN: writes to read-only locations get an
// ERROR response instead of a silently ignored OKAY.
module ahb_slave_controller #(
  parameter int MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  ahb_slave_controller_if.slave  bus,
  input  logic                   hold,
  output logic [3:0]             val_loc,
  output logic                   hwrite_reg,
  output logic [1:0]             state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_BUF_WAIT, S_ERR1, S_ERR2
  } fsm_e;

  fsm_e       fsm_q, fsm_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] val_loc_q, val_loc_d;
  logic       hwrite_reg_q, hwrite_reg_d;

  logic [3:0] dec_loc;
  logic       dec_ok;
  logic       ro_err;
  logic       phase_vld;
  logic       phase_legal;
  logic       buf_loc;
  logic       timeout;
  fsm_e       sample_nxt;

  // Address decode: haddr/hsize pair to location code, or a decode error.
  always_comb begin
    dec_loc = 4'd0;
    dec_ok  = 1'b1;
    unique case ({bus.haddr, bus.hsize})
      {4'h0, 2'd2}: dec_loc = 4'd0;
      {4'h0, 2'd1}: dec_loc = 4'd2;
      {4'h0, 2'd0}: dec_loc = 4'd3;
      {4'h4, 2'd1}: dec_loc = 4'd12;
      {4'h4, 2'd0}: dec_loc = 4'd4;
      {4'h5, 2'd0}: dec_loc = 4'd5;
      {4'h6, 2'd1}: dec_loc = 4'd6;
      {4'h6, 2'd0}: dec_loc = 4'd7;
      {4'h7, 2'd0}: dec_loc = 4'd8;
      {4'h8, 2'd0}: dec_loc = 4'd11;
      {4'hC, 2'd0}: dec_loc = 4'd9;
      {4'hD, 2'd0}: dec_loc = 4'd10;
      default:      dec_ok  = 1'b0;
    endcase
  end

`ifdef AHB_RO_WRITE_ERR_EN
  logic dec_ro;
  assign dec_ro = dec_loc inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11, 4'd12};
  assign ro_err = bus.hwrite && dec_ro;
`else
  assign ro_err = 1'b0;
`endif

  assign phase_vld   = bus.hsel && (bus.htrans inside {2'b10, 2'b11}) && bus.hready;
  assign phase_legal = dec_ok && !ro_err;
  assign buf_loc     = val_loc_q inside {4'd0, 4'd2, 4'd3};
  assign timeout     = hold && (cnt_q == 8'(MAX_WAIT - 1));
  assign sample_nxt  = !phase_vld ? S_IDLE : (phase_legal ? S_ACCESS : S_ERR1);

  // State and data-phase registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q        <= S_IDLE;
      cnt_q        <= 8'd0;
      val_loc_q    <= 4'd0;
      hwrite_reg_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      val_loc_q    <= val_loc_d;
      hwrite_reg_q <= hwrite_reg_d;
    end
  end

  // Next state; every hready=1 cycle doubles as an address-sampling cycle.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE:     fsm_d = sample_nxt;
      S_ACCESS:   fsm_d = buf_loc ? S_BUF_WAIT : sample_nxt;
      S_BUF_WAIT: begin
        if (bus.hready)   fsm_d = sample_nxt;
        else if (timeout) fsm_d = S_ERR1;
      end
      S_ERR1:     fsm_d = S_ERR2;
      S_ERR2:     fsm_d = sample_nxt;
      default:    fsm_d = S_IDLE;
    endcase
    // Wait counter only runs while staying in BUF_WAIT; cleared on entry.
    cnt_d        = (fsm_q == S_BUF_WAIT && fsm_d == S_BUF_WAIT) ? cnt_q + 8'd1 : 8'd0;
    val_loc_d    = (phase_vld && phase_legal) ? dec_loc : val_loc_q;
    hwrite_reg_d = phase_vld ? bus.hwrite : hwrite_reg_q;
  end

  // Outputs; buffer completion needs hold low and at least one full wait cycle.
  always_comb begin
    state      = 2'd0;
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    unique case (fsm_q)
      S_IDLE:     ;
      S_ACCESS: begin
        state      = 2'd1;
        bus.hready = !buf_loc;
      end
      S_BUF_WAIT: begin
        state      = 2'd3;
        bus.hready = !hold && (cnt_q != 8'd0);
      end
      S_ERR1: begin
        state      = 2'd2;
        bus.hready = 1'b0;
        bus.hresp  = 1'b1;
      end
      S_ERR2: begin
        state      = 2'd2;
        bus.hresp  = 1'b1;
      end
      default: ;
    endcase
  end

  assign val_loc    = val_loc_q;
  assign hwrite_reg = hwrite_reg_q;

endmodule
